mem_arbiter: RTL

Single-port memory arbiter for the core. Shares one synchronous instruction/data memory between the fetch stage (instruction reads) and the load/store unit (data reads and writes). It allows one outstanding transaction and returns each response a fixed `MEM_LAT` cycles after its grant. It provides branch-flush cancellation of in-flight fetches and a starvation guard so that fetch progresses under continuous load/store traffic.

---
 rtl/mem_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory between fetch and load/store, one transaction
// outstanding, fixed-latency responses, flush cancel of fetches and a fetch starvation guard.
module mem_arbiter #(
  parameter int XLEN = 32,
  parameter int MEM_LAT = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ifReq,
  input  logic [31:0]     ifAddr,
  output logic            ifGnt,
  output logic            ifValid,
  output logic [XLEN-1:0] ifData,
  input  logic            flush,
  input  logic            lsReq,
  input  logic            lsWe,
  input  logic [31:0]     lsAddr,
  input  logic [XLEN-1:0] lsWdata,
  output logic            lsGnt,
  output logic            lsValid,
  output logic [XLEN-1:0] lsRdata,
  output logic            memEn,
  output logic            memWe,
  output logic [31:0]     memAddr,
  output logic [XLEN-1:0] memWdata,
  input  logic [XLEN-1:0] memRdata,
  output logic            busy
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic [3:0] starve, starve_nx;
  logic owner_ls, owner_ls_nx, we_q, we_nx, cancel, cancel_nx;
  logic idle, if_elig, if_win, ls_win, resp;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      starve   <= 4'd0;
      owner_ls <= 1'b0;
      we_q     <= 1'b0;
      cancel   <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      starve   <= starve_nx;
      owner_ls <= owner_ls_nx;
      we_q     <= we_nx;
      cancel   <= cancel_nx;
    end
  // Outputs are gated by reset so they drop the moment reset rises, not at the next edge.
  always_comb begin
    idle        = !reset && state == IDLE;
    if_elig     = ifReq && !flush;
    if_win      = idle && if_elig && (!lsReq || starve == 4'(STARVE_MAX));
    ls_win      = idle && lsReq && !if_win;
    resp        = !reset && state == WAIT && cnt == 3'd1;
    ifGnt       = if_win;
    lsGnt       = ls_win;
    memEn       = if_win || ls_win;
    memWe       = ls_win && lsWe;
    memAddr     = ls_win ? lsAddr : if_win ? ifAddr : 32'd0;
    memWdata    = memWe ? lsWdata : '0;
    busy        = !reset && state == WAIT;
    ifValid     = resp && !owner_ls && !cancel && !flush;
    lsValid     = resp && owner_ls;
    ifData      = ifValid ? memRdata : '0;
    lsRdata     = (lsValid && !we_q) ? memRdata : '0;
    state_nx    = state;
    cnt_nx      = cnt;
    owner_ls_nx = owner_ls;
    we_nx       = we_q;
    cancel_nx   = cancel;
    if (memEn) begin
      state_nx    = WAIT;
      cnt_nx      = 3'(MEM_LAT);
      owner_ls_nx = ls_win;
      we_nx       = memWe;
      cancel_nx   = 1'b0;
    end else if (state == WAIT) begin
      state_nx  = resp ? IDLE : WAIT;
      cnt_nx    = resp ? 3'd0 : cnt - 3'd1;
      cancel_nx = resp ? 1'b0 : (cancel || (flush && !owner_ls));
    end
    starve_nx = if_win ? 4'd0 :
                (ls_win && if_elig && starve != 4'(STARVE_MAX)) ? starve + 4'd1 : starve;
  end
endmodule
